// File: rtl/inst_fetch_if.sv
`default_nettype none
// inst_fetch_if: ROM port, IF/ID handshake and redirect bundle for the fetch stage.
// Rev 1.0
interface inst_fetch_if;
    logic [31:0] rom_addr;
    logic        rom_cs;
    logic        rom_stall;
    logic [31:0] rom_dout;
    logic        if_stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output rom_addr, rom_cs, inst_valid, inst_data, inst_pc,
        input  rom_stall, rom_dout, if_stall, redirect_en, redirect_pc
    );

    modport slave (
        input  rom_addr, rom_cs, inst_valid, inst_data, inst_pc,
        output rom_stall, rom_dout, if_stall, redirect_en, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// inst_fetch: PC owner, ROM stall handshake and IF/ID valid/stall output with redirects.
// Rev 1.0
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rom_cs_q, rom_cs_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ipc_q, ipc_d;
    logic        capture;
    logic        consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rom_cs_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 32'h0;
            ipc_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rom_cs_q <= rom_cs_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        // ISSUE never captures: rom_stall may still carry the previous address's ack.
        capture = (state_q == S_WAIT) && !bus.rom_stall && (!valid_q || !bus.if_stall);
        consume = valid_q && !bus.if_stall;

        if (state_q == S_IDLE) begin
            state_d = S_ISSUE;
        end else if (bus.redirect_en) begin
            pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
            valid_d = 1'b0;
            state_d = S_ISSUE;
        end else begin
            if (consume) begin
                valid_d = 1'b0;
            end
            case (state_q)
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (capture) begin
                        data_d  = bus.rom_dout;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        rom_cs_d = (state_d != S_IDLE);
    end

    assign bus.rom_addr   = pc_q >> 2;
    assign bus.rom_cs     = rom_cs_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst_data  = data_q;
    assign bus.inst_pc    = ipc_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// tb_inst_fetch: directed tests of inst_fetch against a negedge-counting ROM model.
// Rev 1.0
module tb_inst_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: restarts a count on every new address, drops stall after the 8th negedge.
    logic [31:0] mem [0:15];
    logic [31:0] lat_addr;
    logic        lat_vld;
    logic [3:0]  cnt;
    logic        stall_r;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1111_1111 * (i + 1);
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_vld  <= 1'b0;
            lat_addr <= 32'h0;
            cnt      <= 4'd0;
            stall_r  <= 1'b1;
        end else if (bus.rom_cs) begin
            if (!lat_vld || bus.rom_addr != lat_addr) begin
                lat_vld  <= 1'b1;
                lat_addr <= bus.rom_addr;
                cnt      <= 4'd1;
                stall_r  <= 1'b1;
            end else if (cnt < 4'd8) begin
                cnt     <= cnt + 4'd1;
                stall_r <= (cnt != 4'd7);
            end
        end
    end

    assign bus.rom_stall = stall_r;
    assign bus.rom_dout  = stall_r ? 32'hDEAD_BEEF : mem[lat_addr[3:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n           = 1'b0;
        bus.if_stall    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    // Returns cycles until inst_valid, or 0 when the bound expires.
    task automatic wait_cap(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.inst_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.if_stall    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) tick();
        checks++; if (bus.rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs got %0b want 0", bus.rom_cs); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.inst_valid); end
        checks++; if (bus.inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.inst_data); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.inst_pc); end
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.rom_addr); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.rom_cs !== 1'b1) begin errors++; $display("FAIL release_rom_cs got %0b want 1", bus.rom_cs); end
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL release_addr got %h want 0", bus.rom_addr); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_data [0:2];
        int n;
        exp_data[0] = 32'h1111_1111;
        exp_data[1] = 32'h2222_2222;
        exp_data[2] = 32'h3333_3333;
        for (int k = 0; k < 3; k++) begin
            wait_cap(n);
            checks++; if (n != 8) begin errors++; $display("FAIL seq%0d_latency got %0d want 8", k, n); end
            checks++; if (bus.inst_pc !== 32'(k * 4)) begin errors++; $display("FAIL seq%0d_pc got %h want %h", k, bus.inst_pc, k * 4); end
            checks++; if (bus.inst_data !== exp_data[k]) begin errors++; $display("FAIL seq%0d_data got %h want %h", k, bus.inst_data, exp_data[k]); end
            checks++; if (bus.rom_addr !== 32'(k + 1)) begin errors++; $display("FAIL seq%0d_addr got %h want %h", k, bus.rom_addr, k + 1); end
        end
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL seq_pulse got %0b want 0", bus.inst_valid); end
    endtask

    task automatic test_if_stall;
        int n;
        int bad;
        do_reset();
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL stall_first_latency got %0d want 8", n); end
        bus.if_stall = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 ||
                bus.inst_data !== 32'h1111_1111 || bus.rom_addr !== 32'h1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
        bus.if_stall = 1'b0;
        tick();
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got %0b want 1", bus.inst_valid); end
        checks++; if (bus.inst_pc !== 32'h4) begin errors++; $display("FAIL stall_release_pc got %h want 4", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h2222_2222) begin errors++; $display("FAIL stall_release_data got %h want 22222222", bus.inst_data); end
    endtask

    task automatic test_redirect_wait;
        int n;
        do_reset();
        wait_cap(n);
        bus.if_stall = 1'b1;
        tick();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0023;
        tick();
        bus.redirect_en = 1'b0;
        bus.if_stall    = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0b want 0", bus.inst_valid); end
        checks++; if (bus.rom_addr !== 32'h8) begin errors++; $display("FAIL redir_addr got %h want 8", bus.rom_addr); end
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL redir_latency got %0d want 8", n); end
        checks++; if (bus.inst_pc !== 32'h20) begin errors++; $display("FAIL redir_pc got %h want 20", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h9999_9999) begin errors++; $display("FAIL redir_data got %h want 99999999", bus.inst_data); end
    endtask

    task automatic test_redirect_ack;
        int n;
        do_reset();
        wait_cap(n);
        repeat (7) tick();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0010;
        tick();
        bus.redirect_en = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_ack_valid got %0b want 0", bus.inst_valid); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL redir_ack_no_capture got %h want 0", bus.inst_pc); end
        checks++; if (bus.rom_addr !== 32'h4) begin errors++; $display("FAIL redir_ack_addr got %h want 4", bus.rom_addr); end
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL redir_ack_latency got %0d want 8", n); end
        checks++; if (bus.inst_pc !== 32'h10) begin errors++; $display("FAIL redir_ack_pc got %h want 10", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h5555_5555) begin errors++; $display("FAIL redir_ack_data got %h want 55555555", bus.inst_data); end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        wait_cap(n);
        bus.if_stall = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rom_cs !== 1'b0) begin errors++; $display("FAIL mid_rom_cs got %0b want 0", bus.rom_cs); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", bus.inst_valid); end
        checks++; if (bus.inst_data !== 32'h0) begin errors++; $display("FAIL mid_data got %h want 0", bus.inst_data); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL mid_pc got %h want 0", bus.inst_pc); end
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got %h want 0", bus.rom_addr); end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.if_stall = 1'b0;
        tick();
        checks++; if (bus.rom_cs !== 1'b1) begin errors++; $display("FAIL mid_restart_cs got %0b want 1", bus.rom_cs); end
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL mid_restart_latency got %0d want 8", n); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL mid_restart_pc got %h want 0", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h1111_1111) begin errors++; $display("FAIL mid_restart_data got %h want 11111111", bus.inst_data); end
    endtask

    task automatic test_wrap;
        int n;
        do_reset();
        wait_cap(n);
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_en = 1'b0;
        checks++; if (bus.rom_addr !== 32'h3FFF_FFFF) begin errors++; $display("FAIL wrap_addr got %h want 3fffffff", bus.rom_addr); end
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL wrap_latency got %0d want 8", n); end
        checks++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h1111_1110) begin errors++; $display("FAIL wrap_data got %h want 11111110", bus.inst_data); end
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h want 0", bus.rom_addr); end
        wait_cap(n);
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got %h want 0", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h1111_1111) begin errors++; $display("FAIL wrap_next_data got %h want 11111111", bus.inst_data); end
    endtask

    task automatic test_back_to_back;
        int n;
        do_reset();
        wait_cap(n);
        tick();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0010;
        tick();
        bus.redirect_pc = 32'h0000_0020;
        tick();
        bus.redirect_en = 1'b0;
        checks++; if (bus.rom_addr !== 32'h8) begin errors++; $display("FAIL b2b_addr got %h want 8", bus.rom_addr); end
        wait_cap(n);
        checks++; if (n != 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", n); end
        checks++; if (bus.inst_pc !== 32'h20) begin errors++; $display("FAIL b2b_pc got %h want 20", bus.inst_pc); end
        checks++; if (bus.inst_data !== 32'h9999_9999) begin errors++; $display("FAIL b2b_data got %h want 99999999", bus.inst_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_stall    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_sequential();
        test_if_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction ROM. It owns the program counter, drives the ROM word address and chip select, and waits out the ROM's variable-latency stall handshake. It presents each fetched instruction with its PC to the IF/ID boundary through a valid/stall handshake, and accepts branch/jump redirects from later stages.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: single clock, all state on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rom_addr`  out  32: ROM word address, always `{2'b00, pc[31:2]}`.
- `rom_cs`  out  1: ROM chip select.
- `rom_stall`  in  1: ROM busy; data not yet valid for the current address.
- `rom_dout`  in  32: ROM read data.
- `if_stall`  in  1: downstream cannot accept; hold the current output.
- `redirect_en`  in  1: load a new PC this cycle.
- `redirect_pc`  in  32: redirect target; bits [1:0] ignored and forced to 0.
- `inst_valid`  out  1: `inst_data`/`inst_pc` hold a valid instruction.
- `inst_data`  out  32: fetched instruction.
- `inst_pc`  out  32: byte PC of `inst_data`.

## Operation
- Reset values: `pc`=RESET_PC, state IDLE, `rom_cs`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
- State machine:
  - **IDLE:** entered only from reset. Goes to ISSUE on the first clock after `rst_n` deasserts.
  - **ISSUE:** the address has just changed; `rom_cs`=1. `rom_stall` is ignored because it may still reflect the previous address's ack for up to one cycle. Always goes to WAIT.
  - **WAIT:** `rom_cs`=1 and the address is held stable.
    - Capture condition: `!rom_stall && (!inst_valid || !if_stall)`.
    - On capture: `inst_data`<=`rom_dout`, `inst_pc`<=`pc`, `inst_valid`<=1, `pc`<=`pc`+4, then go to ISSUE.
    - Otherwise stay in WAIT.
- Consumption: an instruction is consumed at a posedge where `inst_valid && !if_stall`. If it is consumed and nothing is captured in that cycle, `inst_valid`<=0.
- While `inst_valid && if_stall`: `inst_data`, `inst_pc`, `pc` and `rom_addr` are all frozen. The ROM keeps its ack, so capture fires in the first cycle `if_stall` drops.
- Redirect:
  - `redirect_en` takes priority over capture and over consumption.
  - At that posedge: `pc`<=`{redirect_pc[31:2],2'b00}`, `inst_valid`<=0, state <= ISSUE, from any state except IDLE.
  - Any in-flight ROM result is discarded.
  - A redirect during IDLE is ignored.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-fetch: everything returns to reset values immediately, whatever the state or pending handshake.

## Timing
- `rom_addr` and `rom_cs` are registered. They change only at posedges that enter ISSUE, or at the first posedge after reset release.
- Fetch latency from ISSUE entry to capture is 1 + N cycles, where N is the number of WAIT cycles until `rom_stall` is sampled low.
  - With the current ROM (7-count on negedge), an instruction is captured 8 cycles after its address is driven.
  - Throughput is one instruction per 8 cycles.
  - The block must not depend on N.
- `inst_*` outputs change only at posedges, after a capture, a consumption or a redirect.
- Back-to-back redirects each restart ISSUE. Only the last target is fetched.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, RESET_PC=0 → all outputs at reset values. One cycle after release `rom_cs`=1 and `rom_addr`=0.
- **Sequential fetch:** ROM words 0..2 = 32'h11111111, 32'h22222222, 32'h33333333; `if_stall`=0.
  - Expect `inst_valid` pulses carrying (pc 0, 32'h11111111), (pc 4, 32'h22222222), (pc 8, 32'h33333333).
  - Captures are 8 cycles apart; `rom_addr` steps 0, 1, 2.
- **Downstream stall:** hold `if_stall`=1 for 20 cycles after the first capture.
  - Expect `inst_pc`=0 and `inst_data` stable, and `rom_addr`=1 stable throughout.
  - The word-1 capture happens in the first cycle `if_stall`=0.
- **Redirect:**
  - Assert `redirect_en` with `redirect_pc`=32'h0000_0023 during WAIT → `inst_valid`=0 next cycle, `rom_addr`=8, next capture has `inst_pc`=32'h20.
  - Repeat with the redirect in the same cycle `rom_stall` falls → no capture of the old word.
- **Reset mid-fetch:** drop `rst_n` for one cycle in WAIT with `inst_valid`=1 and `if_stall`=1 → outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
- **Wrap:** redirect to 32'hFFFF_FFFC → after that capture, `pc`=0 and the following fetch has `inst_pc`=0.
